// File: rtl/mul32_seq_ctrl_if.sv
// mul32_seq_ctrl_if: start/operand request and busy/done/result response of the sequential multiplier
interface mul32_seq_ctrl_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] result;
    modport master (output start, a, b, input busy, done, result);
    modport slave (input start, a, b, output busy, done, result);
endinterface

// File: rtl/mul32_seq_ctrl.sv
// mul32_seq_ctrl: sequential 32x32->64 shift-and-add multiplier reusing one 32-bit carry look-ahead adder
module cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co
);
    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;
    assign g    = a & b;
    assign p    = a ^ b;
    assign c[0] = ci;
    for (genvar k = 0; k < 8; k++) begin : g_grp
        localparam int B = 4 * k;
        assign c[B+1] = g[B] | (p[B] & c[B]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & c[B]);
        assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                      | (p[B+3] & p[B+2] & p[B+1] & g[B]) | (&p[B+3:B] & c[B]);
    end
    assign s  = p ^ c[31:0];
    assign co = c[32];
endmodule

module mul32_seq_ctrl (
    input  logic              clk,
    input  logic              reset_n,
    mul32_seq_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;
    state_t      state_q;
    logic [31:0] mcand_q;
    logic [63:0] prod_q;
    logic [63:0] prod_d;
    logic [63:0] result_q;
    logic [4:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] sum;
    logic        co;
    cla32 u_add (.a(prod_q[63:32]), .b(mcand_q), .ci(1'b0), .s(sum), .co(co));
    // one iteration: add the multiplicand into the upper half when the multiplier LSB is set, then shift right keeping the carry
    always_comb prod_d = prod_q[0] ? {co, sum, prod_q[31:1]} : {1'b0, prod_q[63:1]};
    // control FSM with operand/product registers and registered handshake outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            prod_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    mcand_q <= bus.a;
                    prod_q  <= {32'h0, bus.b};
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                    state_q <= EXEC;
                end
                EXEC: begin
                    prod_q <= prod_d;
                    cnt_q  <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        result_q <= prod_d;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule
